// File: rtl/markov_predictor_n_if.sv
// Handshake bundle between the round sequencer, the
// predictor and the scoring/display logic.
interface markov_predictor_n_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_move;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_choice;
  logic [1:0]       out_pred;
  logic [CNT_W-1:0] out_count;
  logic             out_warm;
  logic             err_illegal;

  modport master (
    output in_valid,
    output in_move,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_choice,
    input  out_pred,
    input  out_count,
    input  out_warm,
    input  err_illegal
  );

  modport slave (
    input  in_valid,
    input  in_move,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_choice,
    output out_pred,
    output out_count,
    output out_warm,
    output err_illegal
  );
endinterface

// File: rtl/markov_predictor_n.sv
// Order-HIST Markov rock-paper-scissors opponent: learns
// transition counts per context and plays beats(prediction).
module markov_predictor_n #(
  parameter int          HIST      = 2,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic              clock,
  input logic              reset,
  markov_predictor_n_if.slave io
);

  localparam int NUM_CTX = 3 ** HIST;
  localparam int CTX_W =
    (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int HC_W  = $clog2(HIST + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    UPDATE,
    PREDICT,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q [NUM_CTX][3];
  logic [CNT_W-1:0] cnt_d [NUM_CTX][3];

  logic [CTX_W-1:0] clr_idx_q, clr_idx_d;
  logic [CTX_W-1:0] ctx_q, ctx_d;
  logic [HC_W-1:0]  hist_q, hist_d;
  logic [1:0]       mv_q, mv_d;
  logic             upd_warm_q, upd_warm_d;
  logic [15:0]      lfsr_q, lfsr_d;

  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [1:0]       choice_q, choice_d;
  logic [1:0]       pred_q, pred_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             warm_q, warm_d;

  logic [CNT_W-1:0] c0, c1, c2, cmx;
  logic [2:0]       tie;
  logic [1:0]       rnd3, arg;

  function automatic logic [1:0] beats(
    input logic [1:0] m
  );
    case (m)
      2'b00:   beats = 2'b10;
      2'b01:   beats = 2'b00;
      default: beats = 2'b01;
    endcase
  endfunction

  assign c0 = cnt_q[ctx_q][0];
  assign c1 = cnt_q[ctx_q][1];
  assign c2 = cnt_q[ctx_q][2];

  assign rnd3 = (lfsr_q[1:0] == 2'b11)
              ? {1'b0, lfsr_q[2]} : lfsr_q[1:0];

  // Argmax over the current context; ties broken by LFSR.
  always_comb begin
    cmx = c0;
    if (c1 > cmx) cmx = c1;
    if (c2 > cmx) cmx = c2;
    tie = {c2 == cmx, c1 == cmx, c0 == cmx};
    arg = rnd3;
    unique case (tie)
      3'b111:  arg = rnd3;
      3'b011:  arg = lfsr_q[0] ? 2'd1 : 2'd0;
      3'b101:  arg = lfsr_q[0] ? 2'd2 : 2'd0;
      3'b110:  arg = lfsr_q[0] ? 2'd2 : 2'd1;
      3'b001:  arg = 2'd0;
      3'b010:  arg = 2'd1;
      3'b100:  arg = 2'd2;
      default: arg = rnd3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_idx_d  = clr_idx_q;
    ctx_d      = ctx_q;
    hist_d     = hist_q;
    mv_d       = mv_q;
    upd_warm_d = upd_warm_q;
    lfsr_d     = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^
                  lfsr_q[12] ^ lfsr_q[10]};
    rdy_d      = rdy_q;
    vld_d      = vld_q;
    err_d      = 1'b0;
    choice_d   = choice_q;
    pred_d     = pred_q;
    count_d    = count_q;
    warm_d     = warm_q;

    unique case (state_q)
      CLEAR: begin
        for (int m = 0; m < 3; m++)
          cnt_d[clr_idx_q][m] = '0;
        clr_idx_d = clr_idx_q + CTX_W'(1);
        if (clr_idx_q == CTX_W'(NUM_CTX - 1)) begin
          clr_idx_d = '0;
          state_d   = IDLE;
          rdy_d     = 1'b1;
        end
      end

      IDLE: begin
        if (io.in_valid && rdy_q) begin
          if (io.in_move == 2'b11) begin
            err_d = 1'b1;
          end else begin
            mv_d    = io.in_move;
            rdy_d   = 1'b0;
            state_d = UPDATE;
          end
        end
      end

      UPDATE: begin
        // The warm flag reflects history before this move.
        upd_warm_d = (hist_q != HC_W'(HIST));
        if (hist_q == HC_W'(HIST)) begin
          if (cnt_q[ctx_q][mv_q] == CMAX) begin
            for (int m = 0; m < 3; m++)
              cnt_d[ctx_q][m] = cnt_q[ctx_q][m] >> 1;
            cnt_d[ctx_q][mv_q] =
              (CMAX >> 1) + CNT_W'(1);
          end else begin
            cnt_d[ctx_q][mv_q] =
              cnt_q[ctx_q][mv_q] + CNT_W'(1);
          end
        end else begin
          hist_d = hist_q + HC_W'(1);
        end
        ctx_d = CTX_W'((int'(ctx_q) * 3 +
                        int'(mv_q)) % NUM_CTX);
        state_d = PREDICT;
      end

      PREDICT: begin
        if (upd_warm_q) begin
          pred_d  = rnd3;
          count_d = '0;
          warm_d  = 1'b1;
        end else begin
          pred_d  = arg;
          count_d = cmx;
          warm_d  = 1'b0;
        end
        choice_d = beats(pred_d);
        vld_d    = 1'b1;
        state_d  = HOLD;
      end

      HOLD: begin
        if (io.out_ready) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
    if (!reset) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      ctx_q      <= '0;
      hist_q     <= '0;
      mv_q       <= '0;
      upd_warm_q <= 1'b1;
      lfsr_q     <= LFSR_SEED;
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      choice_q   <= '0;
      pred_q     <= '0;
      count_q    <= '0;
      warm_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ctx_q      <= ctx_d;
      hist_q     <= hist_d;
      mv_q       <= mv_d;
      upd_warm_q <= upd_warm_d;
      lfsr_q     <= lfsr_d;
      rdy_q      <= rdy_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      choice_q   <= choice_d;
      pred_q     <= pred_d;
      count_q    <= count_d;
      warm_q     <= warm_d;
    end
  end

  assign io.in_ready    = rdy_q;
  assign io.out_valid   = vld_q;
  assign io.err_illegal = err_q;
  assign io.out_choice  = choice_q;
  assign io.out_pred    = pred_q;
  assign io.out_count   = count_q;
  assign io.out_warm    = warm_q;

endmodule

// File: tb/tb_markov_predictor_n.sv
// Directed scoreboard bench: a default instance and a
// CNT_W=2 instance driven in lockstep.
module tb_markov_predictor_n;

  logic clock;
  logic reset;

  markov_predictor_n_if #(.CNT_W(8)) ifa ();
  markov_predictor_n_if #(.CNT_W(2)) ifb ();

  markov_predictor_n #(
    .HIST(2), .CNT_W(8), .LFSR_SEED(16'hACE1)
  ) u_a (
    .clock(clock), .reset(reset), .io(ifa)
  );

  markov_predictor_n #(
    .HIST(2), .CNT_W(2), .LFSR_SEED(16'hACE1)
  ) u_b (
    .clock(clock), .reset(reset), .io(ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       warm;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [2:0] m0;
    logic [2:0] m1;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   hist;
  int   ctx;
  int   t[2][9][3];

  function automatic logic [1:0] beats(
    input logic [1:0] m
  );
    case (m)
      2'b00:   beats = 2'b10;
      2'b01:   beats = 2'b00;
      default: beats = 2'b01;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    hist = 0;
    ctx  = 0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 9; c++)
        for (int j = 0; j < 3; j++)
          t[k][c][j] = 0;
  endtask

  task automatic model(input logic [1:0] mv);
    exp_t       e;
    int         mx;
    int         best;
    logic [2:0] msk;
    logic       w;
    w = (hist < 2);
    e = '0;
    e.warm = w;
    for (int k = 0; k < 2; k++) begin
      mx = (k == 0) ? 255 : 3;
      if (!w) begin
        if (t[k][ctx][mv] == mx) begin
          for (int j = 0; j < 3; j++)
            t[k][ctx][j] = t[k][ctx][j] / 2;
          t[k][ctx][mv] = mx / 2 + 1;
        end else begin
          t[k][ctx][mv] = t[k][ctx][mv] + 1;
        end
      end
    end
    if (w) hist = hist + 1;
    ctx = (ctx * 3 + int'(mv)) % 9;
    for (int k = 0; k < 2; k++) begin
      best = t[k][ctx][0];
      for (int j = 1; j < 3; j++)
        if (t[k][ctx][j] > best) best = t[k][ctx][j];
      for (int j = 0; j < 3; j++)
        msk[j] = (t[k][ctx][j] == best);
      if (w) begin
        msk  = 3'b111;
        best = 0;
      end
      if (k == 0) begin
        e.cnt0 = 8'(best);
        e.m0   = msk;
      end else begin
        e.cnt1 = 8'(best);
        e.m1   = msk;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v,
                       input logic [1:0] mv);
    ifa.in_valid = v;
    ifb.in_valid = v;
    ifa.in_move  = mv;
    ifb.in_move  = mv;
  endtask

  task automatic set_ordy(input logic r);
    ifa.out_ready = r;
    ifb.out_ready = r;
  endtask

  task automatic cmp_out(input exp_t e);
    logic [2:0] m;
    logic [1:0] p;
    m = e.m0;
    p = ifa.out_pred;
    chk("warm_a", ifa.out_warm, e.warm);
    chk("count_a", ifa.out_count, e.cnt0);
    chk("pred_a", (p != 2'b11) && m[p], 1);
    chk("choice_a", ifa.out_choice, beats(p));
    m = e.m1;
    p = ifb.out_pred;
    chk("warm_b", ifb.out_warm, e.warm);
    chk("count_b", ifb.out_count, e.cnt1);
    chk("pred_b", (p != 2'b11) && m[p], 1);
    chk("choice_b", ifb.out_choice, beats(p));
  endtask

  // Starts and ends on a negedge; moves are accepted at
  // the posedge in between.
  task automatic send(input logic [1:0] mv);
    int n;
    n = 0;
    while (ifa.in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("accept_ready", ifa.in_ready, 1);
    drive(1'b1, mv);
    if (mv != 2'b11) model(mv);
    @(negedge clock);
    drive(1'b0, 2'b00);
  endtask

  task automatic expect_out(output exp_t e);
    chk("busy", ifa.in_ready, 0);
    chk("lat_t1", ifa.out_valid, 0);
    @(negedge clock);
    chk("lat_t2", ifa.out_valid, 0);
    @(negedge clock);
    chk("lat_out_a", ifa.out_valid, 1);
    chk("lat_out_b", ifb.out_valid, 1);
    chk("sb_nonempty", exp_q.size() > 0, 1);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    cmp_out(e);
  endtask

  task automatic move(input logic [1:0] mv);
    exp_t e;
    send(mv);
    expect_out(e);
    @(negedge clock);
    chk("drain_vld", ifa.out_valid, 0);
    chk("drain_rdy", ifa.in_ready, 1);
  endtask

  task automatic clear_check();
    for (int i = 0; i < 9; i++) begin
      chk("clr_rdy", ifa.in_ready, 0);
      chk("clr_vld", ifa.out_valid, 0);
      @(negedge clock);
    end
    chk("clr_done_a", ifa.in_ready, 1);
    chk("clr_done_b", ifb.in_ready, 1);
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    mdl_reset();
    reset = 1'b0;
    drive(1'b0, 2'b00);
    set_ordy(1'b1);

    // Reset and table clear
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("rst_warm", ifa.out_warm, 1);
    chk("rst_count", ifa.out_count, 0);
    chk("rst_choice", ifa.out_choice, 0);
    chk("rst_pred", ifa.out_pred, 0);
    chk("rst_err", ifa.err_illegal, 0);
    clear_check();

    // Warm-up then learning on a constant stream
    for (int i = 0; i < 6; i++) move(2'b00);

    // Alternating scissors/paper
    for (int i = 0; i < 10; i++)
      move((i % 2 == 0) ? 2'b01 : 2'b10);

    // Back-pressure with in_valid held high
    set_ordy(1'b0);
    send(2'b01);
    expect_out(e);
    drive(1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_vld", ifa.out_valid, 1);
      chk("hold_rdy", ifa.in_ready, 0);
      cmp_out(e);
    end
    set_ordy(1'b1);
    @(negedge clock);
    drive(1'b0, 2'b00);
    chk("hold_rel_vld", ifa.out_valid, 0);
    chk("hold_rel_rdy", ifa.in_ready, 1);
    @(negedge clock);
    chk("no_extra_vld", ifa.out_valid, 0);

    // Illegal move
    send(2'b11);
    chk("ill_err_a", ifa.err_illegal, 1);
    chk("ill_err_b", ifb.err_illegal, 1);
    chk("ill_vld", ifa.out_valid, 0);
    chk("ill_rdy", ifa.in_ready, 1);
    @(negedge clock);
    chk("ill_err_off", ifa.err_illegal, 0);
    chk("ill_vld2", ifa.out_valid, 0);
    move(2'b10);
    move(2'b01);

    // Reset while holding an output
    set_ordy(1'b0);
    send(2'b10);
    expect_out(e);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("rst_hold_vld", ifa.out_valid, 0);
    chk("rst_hold_warm", ifa.out_warm, 1);
    mdl_reset();
    clear_check();
    set_ordy(1'b1);
    move(2'b00);
    move(2'b00);
    move(2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/markov_predictor_n.md
Name: markov_predictor_n

Overview:
- Parametrised next-generation rock-paper-scissors opponent model.
- Keeps a table of saturating transition counters indexed by the last HIST user moves, taken as a base-3 context.
- For each user move it updates the table, predicts the user's next move and emits the move that beats it.
- Sits between the round sequencer (move source) and the game scoring/display logic, connected by valid/ready handshakes.

Parameters:
HIST, 2, number of previous user moves forming the context; NUM_CTX = 3^HIST.
CNT_W, 8, width of each transition counter.
LFSR_SEED, 16'hACE1, non-zero reset seed of the internal 16-bit LFSR.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  user move offered
in_ready  output  1  block can accept a move
in_move  input  2  user move: 00 rock, 01 scissors, 10 paper, 11 illegal
out_valid  output  1  prediction available
out_ready  input  1  consumer accepts prediction
out_choice  output  2  computer move, same encoding
out_pred  output  2  predicted next user move
out_count  output  CNT_W  counter value of out_pred in the current context; 0 during warm-up
out_warm  output  1  1 = history not yet full, so out_choice is random
err_illegal  output  1  one-cycle pulse when an illegal move is accepted

Behaviour:
- Encoding and beats map: beats(rock)=paper 10; beats(scissors)=rock 00; beats(paper)=scissors 01. out_choice = beats(out_pred).
- Reset (reset==0 at a posedge, in any state, mid-operation included):
  - next state CLEAR;
  - outputs: out_valid=0, in_ready=0, err_illegal=0, out_choice=0, out_pred=0, out_count=0, out_warm=1;
  - internal: hist_cnt=0, ctx=0, clr_idx=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle except while reset is low.
- rnd3: rnd3 = (lfsr[1:0]==11) ? {1'b0,lfsr[2]} : lfsr[1:0].
- FSM states: CLEAR, IDLE, UPDATE, PREDICT, HOLD.
  - CLEAR: zero all three counters of row clr_idx; increment clr_idx. After row NUM_CTX-1 go to IDLE. CLEAR lasts exactly NUM_CTX cycles.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_move and go to UPDATE.
  - Illegal move (11): err_illegal=1 for one cycle, return to IDLE. No table change, no history change, no output.
  - UPDATE: if hist_cnt==HIST, increment cnt[ctx][move].
    - Saturation: if cnt[ctx][move]==2^CNT_W-1, all three counters of ctx are shifted right by 1, then the target gets +1. Result: target=(max>>1)+1, others halved.
    - Then ctx <= (ctx*3 + move) mod NUM_CTX (most recent move is the least-significant digit).
    - hist_cnt <= min(hist_cnt+1, HIST).
    - Go to PREDICT.
  - PREDICT, when hist_cnt<HIST: out_pred=rnd3, out_count=0, out_warm=1.
  - PREDICT, otherwise: read cnt[ctx][0..2] and take the argmax.
    - Unique max: that move.
    - Two-way tie for max: lower encoding if lfsr[0]==0, else higher.
    - Three-way tie: rnd3.
    - out_warm=0; out_count=max value. Set out_valid=1 and go to HOLD.
  - HOLD: out_valid=1; out_choice, out_pred, out_count and out_warm are stable; in_ready=0. On out_ready go to IDLE (out_valid=0 next cycle).
- Latency: move accepted at posedge T gives out_valid=1 after posedge T+2. in_ready stays 0 from T+1 until the cycle after out_ready handshake.
- in_valid while in_ready=0 is ignored; no buffering.
- Counter arithmetic is unsigned CNT_W and never wraps.

Test Plan:
1. Reset low 3 cycles, then high, with HIST=2 -> in_ready=0 for exactly 9 cycles after release, then 1. out_valid=0 throughout.
2. Feed rock, rock with out_ready=1 -> two outputs with out_warm=1, out_count=0, out_choice in {00,01,10}. The third rock gives out_warm=0, out_pred=00, out_choice=10, out_count=1.
3. CNT_W=2, feed rock x6 -> out_count sequence from the 3rd move is 1,2,3,2 (saturation halving). out_pred stays 00.
4. After history full, send scissors,paper,scissors,paper,... -> once each context has counts, out_pred alternates correctly and out_choice equals beats(out_pred) each round. Latency is exactly 2 cycles from accept.
5. Hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid and outputs stable, in_ready=0, no extra move consumed.
6. Send 11 -> err_illegal pulses one cycle, no out_valid, next legal move behaves as if 11 never occurred. Assert reset during HOLD -> next cycle out_valid=0 and a full 9-cycle CLEAR follows.
